// File: rtl/seg7_pkg.sv
// Shared FSM state type and active-low seven-segment codes (bit0 = a ... bit6 = g).
package seg7_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Indexed by nibble value; element 0 is the last entry in the concatenation.
  localparam logic [15:0][6:0] SEG_HEX = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,  // F E d C
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,  // b A 9 8
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,  // 7 6 5 4
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000   // 3 2 1 0
  };
endpackage

// File: rtl/seg7_encode.sv
// Combinational nibble to active-low segment encoder, one per digit.
module seg7_encode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_HEX[nib];
endmodule

// File: rtl/seg7_dec_display.sv
// Binary to hex/decimal seven-segment display driver with double-dabble BCD
// conversion, leading-zero blanking and overflow dashes.
module seg7_dec_display
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DIGITS   = 8,
  parameter int BLANK_LZ = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   in_mode,
  output logic [DIGITS-1:0][6:0] hex_n,
  output logic                   done,
  output logic                   overflow
);
  localparam int BW = 4*(DIGITS+1);
  localparam int CW = $clog2(WIDTH);
  localparam int EW = (WIDTH > 4*DIGITS) ? WIDTH : 4*DIGITS;

  state_t                   state, state_nx;
  logic [WIDTH-1:0]         data_r;
  logic                     mode_r;
  logic [BW-1:0]            bcd, adj, bcd_nx;
  logic                     lost;
  logic [CW-1:0]            cnt;
  logic [EW-1:0]            data_ext;
  logic [DIGITS-1:0][3:0]   nib;
  logic [DIGITS-1:0][6:0]   seg, disp;
  logic [DIGITS:0]          lead;
  logic                     hex_fit, fit;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = in_mode ? SHIFT : LATCH;
      end
      SHIFT:   if (cnt == CW'(WIDTH-1)) state_nx = LATCH;
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Double-dabble step: correct every nibble, then shift in the next data bit.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < DIGITS+1; i++)
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    bcd_nx = {adj[BW-2:0], data_r[WIDTH-1]};
  end

  assign data_ext = EW'(data_r);

  generate
    if (EW > 4*DIGITS) begin : g_hex_hi
      assign hex_fit = (data_ext[EW-1:4*DIGITS] == '0);
    end else begin : g_hex_nohi
      assign hex_fit = 1'b1;
    end
  endgenerate

  // A bit falling off the top of the BCD register means the value is far too large.
  assign fit = mode_r ? (!lost && bcd[BW-1 -: 4] == 4'd0) : hex_fit;

  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      nib[i] = mode_r ? bcd[4*i +: 4] : data_ext[4*i +: 4];
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    seg7_encode u_enc (.nib(nib[g]), .seg(seg[g]));
  end

  always_comb begin
    lead[DIGITS] = 1'b0;
    for (int i = DIGITS-1; i >= 0; i--)
      lead[i] = lead[i+1] | (nib[i] != 4'd0);
    for (int i = 0; i < DIGITS; i++) begin
      if (!fit)                                 disp[i] = SEG_DASH;
      else if (BLANK_LZ == 0 || i == 0 || lead[i]) disp[i] = seg[i];
      else                                      disp[i] = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r   <= '0;
      mode_r   <= 1'b0;
      bcd      <= '0;
      lost     <= 1'b0;
      cnt      <= '0;
      hex_n    <= {DIGITS{SEG_BLANK}};
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= (state == LATCH);
      case (state)
        IDLE: if (in_valid) begin
          data_r <= in_data;
          mode_r <= in_mode;
          bcd    <= '0;
          lost   <= 1'b0;
          cnt    <= '0;
        end
        SHIFT: begin
          bcd    <= bcd_nx;
          lost   <= lost | adj[BW-1];
          data_r <= data_r << 1;
          cnt    <= cnt + 1'b1;
        end
        LATCH: begin
          hex_n    <= disp;
          overflow <= !fit;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seg7_dec_display.sv
// Scoreboarded random/directed bench for seg7_dec_display, two instances
// (leading-zero blanking on and off) fed from the same stimulus.
module tb_seg7_dec_display;
  localparam int W = 32;
  localparam int D = 8;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0;
  logic [W-1:0] in_data = '0;
  logic rdy_a, rdy_b, done_a, done_b, ovf_a, ovf_b;
  logic [D-1:0][6:0] hex_a, hex_b;

  seg7_dec_display #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_a),
    .in_data(in_data), .in_mode(in_mode), .hex_n(hex_a), .done(done_a), .overflow(ovf_a));
  seg7_dec_display #(.WIDTH(W), .DIGITS(D), .BLANK_LZ(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_b),
    .in_data(in_data), .in_mode(in_mode), .hex_n(hex_b), .done(done_b), .overflow(ovf_b));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int passed = 0, total = 0;

  typedef struct {
    logic [D-1:0][6:0] hex1;
    logic [D-1:0][6:0] hex0;
    logic              ovf;
    int                due;
  } exp_t;
  exp_t sb[$];
  logic [D-1:0][6:0] shown;
  localparam logic [D-1:0][6:0] ALL_BLANK = {D{7'b1111111}};

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000; 10: return 7'b0001000; 11: return 7'b0000011;
     12: return 7'b1000110; 13: return 7'b0100001; 14: return 7'b0000110;
      default: return 7'b0001110;
    endcase
  endfunction

  function automatic void model(input logic [W-1:0] v, input bit dec, input bit blz,
                                output logic [D-1:0][6:0] hx, output logic ovf);
    longint unsigned val, lim, p;
    int dig[D];
    int msd;
    val = 64'(v);
    lim = 1;
    for (int i = 0; i < D; i++) lim = lim * 10;
    ovf = dec ? (val >= lim) : ((val >> (4*D)) != 0);
    p = 1;
    msd = 0;
    for (int i = 0; i < D; i++) begin
      dig[i] = dec ? int'((val / p) % 10) : int'((val >> (4*i)) & 15);
      p = p * 10;
      if (dig[i] != 0) msd = i;
    end
    for (int i = 0; i < D; i++)
      hx[i] = ovf ? 7'b0111111 : (blz && i > msd) ? 7'b1111111 : seg_of(dig[i]);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (done_a || done_b)) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL spurious_done actual=%0d required=0 cycle=%0d", done_a, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hex_blz1", 64'(hex_a), 64'(e.hex1));
        chk("hex_blz0", 64'(hex_b), 64'(e.hex0));
        chk("overflow", 64'(ovf_a), 64'(e.ovf));
        chk("overflow_b", 64'(ovf_b), 64'(e.ovf));
        chk("done_latency", 64'(cyc), 64'(e.due));
        shown = e.hex1;
      end
    end
  end

  task automatic send(input logic [W-1:0] v, input bit dec);
    exp_t e;
    int n = 0;
    while (!rdy_a && n < 200) begin @(negedge clk); n++; end
    if (!rdy_a) begin
      total++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    in_valid = 1'b1; in_data = v; in_mode = dec;
    model(v, dec, 1'b1, e.hex1, e.ovf);
    model(v, dec, 1'b0, e.hex0, e.ovf);
    @(posedge clk); #1;
    e.due = cyc + (dec ? W + 1 : 1);
    sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (sb.size() != 0) begin
      total++;
      $display("FAIL done_timeout actual=%0d pending required=0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_hex_a"}, 64'(hex_a), 64'(ALL_BLANK));
    chk({tag, "_hex_b"}, 64'(hex_b), 64'(ALL_BLANK));
    chk({tag, "_ovf"},   64'(ovf_a), 64'd0);
    chk({tag, "_done"},  64'(done_a), 64'd0);
    chk({tag, "_ready"}, 64'(rdy_a), 64'd1);
  endtask

  initial begin
    shown = ALL_BLANK;
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    send(32'd12345, 1'b1);              // accepted on the first edge after release
    wait_idle();
    send(32'h0001DDDD, 1'b0);
    wait_idle();
    send(32'd0, 1'b1);
    wait_idle();
    send(32'hFFFFFFFF, 1'b1);
    wait_idle();
    send(32'd7, 1'b1);
    wait_idle();
    send(32'd99999999, 1'b1);
    wait_idle();
    send(32'd100000000, 1'b1);
    wait_idle();
    send(32'hFFFFFFFF, 1'b0);
    wait_idle();

    // Offers made while busy are dropped and the old display is held.
    send(32'd12345, 1'b1);
    repeat (4) @(negedge clk);
    chk("busy_ready", 64'(rdy_a), 64'd0);
    chk("hold_display", 64'(hex_a), 64'(shown));
    in_valid = 1'b1; in_data = 32'd99; in_mode = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

    // Reset mid-conversion: no done, display blanked.
    send(32'd54321, 1'b1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #2;
    chk_reset_state("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_hold", 64'(hex_a), 64'(ALL_BLANK));

    for (int k = 0; k < 40; k++) begin
      send($urandom >> $urandom_range(0, 31), 1'($urandom_range(0, 1)));
      if (k % 4 == 0) wait_idle();
    end
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/seg7_dec_display.md
SEG7_DEC_DISPLAY -- requirements
Module: seg7_dec_display

Interface
REQ-001 Parameter WIDTH, default 32, is the binary input width in bits (4..64).
REQ-002 Parameter DIGITS, default 8, is the number of seven-segment digits driven (1..8).
REQ-003 Parameter BLANK_LZ, default 1, enables leading-zero blanking when set to 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port in_valid, input, 1 bit: a new value is offered on in_data.
REQ-007 Port in_ready, output, 1 bit: the block accepts a value this cycle.
REQ-008 Port in_data, input, WIDTH bits: unsigned binary value to display.
REQ-009 Port in_mode, input, 1 bit: 0 selects hex display, 1 selects decimal display; sampled with in_data.
REQ-010 Port hex_n, output, DIGITS x 7 bits: active-low segment codes; bit0 = a … bit6 = g; index 0 is the least-significant digit.
REQ-011 Port done, output, 1 bit: one-cycle pulse when hex_n has been updated.
REQ-012 Port overflow, output, 1 bit: the last displayed value did not fit in DIGITS digits.

Function
REQ-013 FSM states SHALL be IDLE, SHIFT and LATCH; in_ready SHALL be 1 only in IDLE.
REQ-014 Accept SHALL occur on a rising edge with in_valid=1 in IDLE; in_data and in_mode are captured at that edge.
REQ-015 Hex mode SHALL go IDLE->LATCH; decimal mode SHALL go IDLE->SHIFT.
REQ-016 SHIFT SHALL run exactly WIDTH cycles of double-dabble (add 3 to each BCD nibble >=5, then shift left 1); BCD register is 4*(DIGITS+1) bits wide to detect overflow; then ->LATCH.
REQ-017 LATCH SHALL update hex_n and overflow, pulse done for one cycle, then return to IDLE.
REQ-018 Latency from accept edge to done high SHALL be 1 cycle (hex) or WIDTH+1 cycles (decimal).
REQ-019 hex_n SHALL hold its previous value throughout a conversion.
REQ-020 in_valid while not in IDLE SHALL be ignored; no value is queued.
REQ-021 Digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110, blank=1111111, dash=0111111.
REQ-022 With BLANK_LZ=1, zero digits above the most-significant non-zero digit SHALL be blank; digit 0 SHALL always be shown.
REQ-023 Decimal overflow (value >= 10^DIGITS) or hex overflow (in_data bits above 4*DIGITS-1 non-zero) SHALL set overflow=1 and drive every digit to dash.
REQ-024 A conversion that fits SHALL clear overflow at LATCH.

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, all hex_n digits blank, done=0, overflow=0, in_ready=1.
REQ-026 Reset during SHIFT SHALL abort the conversion with no done pulse.
REQ-027 The first accept is permitted on the first rising edge after rst_n deasserts.

Structure
REQ-028 Package seg7_pkg SHALL hold the state enum and the segment-code constants, including blank and dash.
REQ-029 Sub-module seg7_encode SHALL be a combinational nibble-to-segment encoder instantiated once per digit.

Verification
REQ-030 Decimal mode, WIDTH=32, DIGITS=8, in_data=12345 -> done exactly 33 cycles after accept; HEX4..0 show 1,2,3,4,5; HEX7..5 blank; overflow=0.
REQ-031 Hex mode, in_data=32'h0001DDDD -> done 1 cycle after accept; HEX4..0 show 1,d,d,d,d; HEX7..5 blank.
REQ-032 Decimal mode, in_data=0 -> HEX0=1000000 and all other digits blank; with BLANK_LZ=0, all digits=1000000.
REQ-033 DIGITS=8, decimal mode, in_data=32'hFFFFFFFF -> overflow=1 and all digits=0111111; then in_data=7 -> overflow=0 and HEX0=1111000.
REQ-034 Accept 12345, assert in_valid with 99 at cycle 5 -> 99 is ignored and the display shows 12345; pulse rst_n low at cycle 10 of a second conversion -> all digits blank, no done pulse, in_ready=1.
